// File: rtl/attn_job_loader_pkg.sv
`default_nettype none
// ============================================================================
// attn_job_loader_pkg : shared constants and state encoding for the loader
// Revision: 1.0
// ============================================================================
package attn_job_loader_pkg;

    localparam int unsigned ELEM_W   = 16;
    localparam int unsigned OPD_W    = 512;
    localparam int unsigned RES_W    = 256;
    localparam int unsigned BEAT_QRY = 32;
    localparam int unsigned BEAT_VAL = 64;
    localparam int unsigned BEAT_END = 96;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_ARM     = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRAIN   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/attn_job_loader_serializer.sv
`default_nettype none
// ============================================================================
// attn_res_serializer : holds the captured result and streams it as words
// Revision: 1.0
// ============================================================================
module attn_res_serializer
    import attn_job_loader_pkg::*;
#(
    parameter int DATA_W    = ELEM_W,
    parameter int RES_ELEMS = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [RES_W-1:0]  res_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    localparam int IDX_W = $clog2(RES_ELEMS);

    logic [RES_W-1:0] res_q, res_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             at_last;

    assign at_last   = (idx_q == IDX_W'(RES_ELEMS - 1));
    assign out_valid = valid_q;
    assign out_last  = valid_q && at_last;
    assign done      = valid_q && out_ready && at_last;

    always_comb begin
        res_d   = res_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load) begin
            res_d   = res_in;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            // Index wraps back to 0 after the last word
            idx_d = idx_q + IDX_W'(1);
            if (at_last) begin
                valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < RES_ELEMS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                out_data = res_q[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/attn_job_loader.sv
`default_nettype none
// ============================================================================
// attn_job_loader : loads K/Q/V operands, runs one attention job, drains result
// Optional RUN timeout abort enabled by ATTN_LOADER_TIMEOUT_EN.  Revision: 1.0
// ============================================================================
module attn_job_loader
    import attn_job_loader_pkg::*;
#(
    parameter int DATA_W    = ELEM_W,
    parameter int MAT_ELEMS = 32,
    parameter int RES_ELEMS = 16
`ifdef ATTN_LOADER_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 4096
`endif
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    output logic [MAT_ELEMS*DATA_W-1:0]    key_bus,
    output logic [MAT_ELEMS*DATA_W-1:0]    query_bus,
    output logic [MAT_ELEMS*DATA_W-1:0]    value_bus,
    output logic                           attn_en,
    output logic                           attn_rst_n,
    input  logic [RES_ELEMS*DATA_W-1:0]    attn_res,
    input  logic                           attn_done,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic                           error
);

    state_e           state_q, state_d;
    logic [6:0]       beat_q, beat_d;
    logic [OPD_W-1:0] key_q, key_d, query_q, query_d, value_q, value_d;
    logic             in_ready_q, in_ready_d;
    logic             attn_en_q, attn_en_d;
    logic             attn_rst_n_q, attn_rst_n_d;
    logic             busy_q, busy_d;
    logic             drain_done;

`ifdef ATTN_LOADER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             error_q, error_d;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        key_d   = key_q;
        query_d = query_q;
        value_d = value_q;
`ifdef ATTN_LOADER_TIMEOUT_EN
        run_cnt_d = run_cnt_q;
        error_d   = error_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    for (int k = 0; k < MAT_ELEMS; k++) begin
                        if (beat_q == 7'(k))            key_d[k*DATA_W +: DATA_W]   = in_data;
                        if (beat_q == 7'(k + BEAT_QRY)) query_d[k*DATA_W +: DATA_W] = in_data;
                        if (beat_q == 7'(k + BEAT_VAL)) value_d[k*DATA_W +: DATA_W] = in_data;
                    end
                    beat_d = beat_q + 7'd1;
                    if (beat_q == 7'(BEAT_END - 1)) begin
                        state_d = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                state_d = ST_RUN;
`ifdef ATTN_LOADER_TIMEOUT_EN
                run_cnt_d = '0;
`endif
            end
            ST_RUN: begin
                if (attn_done) begin
                    state_d = ST_CAPTURE;
                end
`ifdef ATTN_LOADER_TIMEOUT_EN
                // Done on the same cycle as the limit takes priority over abort
                else if (run_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    error_d = 1'b1;
                    state_d = ST_LOAD;
                    beat_d  = '0;
                end else begin
                    run_cnt_d = run_cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_CAPTURE: state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_LOAD;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = ST_LOAD;
                beat_d  = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        in_ready_d   = (state_d == ST_LOAD);
        attn_en_d    = (state_d == ST_RUN);
        attn_rst_n_d = (state_d != ST_ARM);
        busy_d       = !((state_d == ST_LOAD) && (beat_d == 7'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            beat_q       <= '0;
            key_q        <= '0;
            query_q      <= '0;
            value_q      <= '0;
            in_ready_q   <= 1'b0;
            attn_en_q    <= 1'b0;
            attn_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            key_q        <= key_d;
            query_q      <= query_d;
            value_q      <= value_d;
            in_ready_q   <= in_ready_d;
            attn_en_q    <= attn_en_d;
            attn_rst_n_q <= attn_rst_n_d;
            busy_q       <= busy_d;
        end
    end

`ifdef ATTN_LOADER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            error_q   <= error_d;
        end
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign in_ready   = in_ready_q;
    assign key_bus    = key_q;
    assign query_bus  = query_q;
    assign value_bus  = value_q;
    assign attn_en    = attn_en_q;
    assign attn_rst_n = attn_rst_n_q;
    assign busy       = busy_q;

    attn_res_serializer #(
        .DATA_W    (DATA_W),
        .RES_ELEMS (RES_ELEMS)
    ) u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (state_q == ST_CAPTURE),
        .res_in    (attn_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (drain_done)
    );

endmodule
`default_nettype wire
